// File: rtl/cmp_search_pkg.sv
// Shared types and helpers for the comparator-driven binary search.
// Optional probe counter output is enabled with CMP_SEARCH_PROBE_CNT_EN.
package cmp_search_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 3;

  // Enough bits to hold WIDTH+1 probes.
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/cmp_binary_search.sv
// Binary search over 0..2^WIDTH-1 driven by external comparator flags.
// Define CMP_SEARCH_PROBE_CNT_EN to expose probe_cnt (probes used by the current/last search).
module cmp_binary_search
  import cmp_search_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] probe,
  input  logic             cmp_greater,
  input  logic             cmp_equal,
  input  logic             cmp_less,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] found_value,
  output logic             err
`ifdef CMP_SEARCH_PROBE_CNT_EN
  ,
  output logic [cnt_w(WIDTH)-1:0] probe_cnt
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Sum in WIDTH+1 bits so lo+hi never overflows before the halving.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] found_value_q, found_value_d;
  logic             err_q, err_d;
  logic             finish;
`ifdef CMP_SEARCH_PROBE_CNT_EN
  logic [cnt_w(WIDTH)-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    probe_d       = probe_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    found_d       = found_q;
    found_value_d = found_value_q;
    err_d         = err_q;
    finish        = 1'b0;
`ifdef CMP_SEARCH_PROBE_CNT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d          = '0;
          hi_d          = MAX_VAL;
          probe_d       = midpoint('0, MAX_VAL);
          busy_d        = 1'b1;
          found_d       = 1'b0;
          found_value_d = '0;
          err_d         = 1'b0;
          state_d       = SEARCH;
`ifdef CMP_SEARCH_PROBE_CNT_EN
          cnt_d         = '0;
`endif
        end
      end
      SEARCH: begin
`ifdef CMP_SEARCH_PROBE_CNT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        case ({cmp_greater, cmp_equal, cmp_less})
          3'b010: begin
            found_d       = 1'b1;
            found_value_d = probe_q;
            finish        = 1'b1;
          end
          3'b001: begin
            if (probe_q == hi_q) begin
              found_d = 1'b0;
              finish  = 1'b1;
            end else begin
              lo_d    = probe_q + ONE;
              probe_d = midpoint(probe_q + ONE, hi_q);
            end
          end
          3'b100: begin
            // probe == lo also covers probe 0, so probe-1 never underflows.
            if (probe_q == lo_q) begin
              found_d = 1'b0;
              finish  = 1'b1;
            end else begin
              hi_d    = probe_q - ONE;
              probe_d = midpoint(lo_q, probe_q - ONE);
            end
          end
          default: begin
            err_d   = 1'b1;
            found_d = 1'b0;
            finish  = 1'b1;
          end
        endcase
        if (finish) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lo_q          <= '0;
      hi_q          <= '0;
      probe_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      found_value_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      probe_q       <= probe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      found_q       <= found_d;
      found_value_q <= found_value_d;
      err_q         <= err_d;
    end
  end

`ifdef CMP_SEARCH_PROBE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign probe_cnt = cnt_q;
`endif

  assign probe       = probe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign found_value = found_value_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cmp_binary_search.sv
// Bench for cmp_binary_search: behavioural comparator closes the loop, a plan-based
// reference model predicts every output each cycle, plus directed latency/value checks.
module tb_cmp_binary_search;

  localparam int W   = 3;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] probe;
  logic         cmp_greater, cmp_equal, cmp_less;
  logic         busy, done, found, err;
  logic [W-1:0] found_value;
`ifdef CMP_SEARCH_PROBE_CNT_EN
  logic [cmp_search_pkg::cnt_w(W)-1:0] probe_cnt;
`endif

  int target;
  int inj;     // 0: honest comparator, 1: greater+less both set, 2: no flag set
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  cmp_binary_search #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .probe       (probe),
    .cmp_greater (cmp_greater),
    .cmp_equal   (cmp_equal),
    .cmp_less    (cmp_less),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .found_value (found_value),
    .err         (err)
`ifdef CMP_SEARCH_PROBE_CNT_EN
    ,
    .probe_cnt   (probe_cnt)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    cmp_greater = 1'b0;
    cmp_equal   = 1'b0;
    cmp_less    = 1'b0;
    if (inj == 1) begin
      cmp_greater = 1'b1;
      cmp_less    = 1'b1;
    end else if (inj == 0) begin
      cmp_greater = int'(probe) > target;
      cmp_equal   = int'(probe) == target;
      cmp_less    = int'(probe) < target;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sequence of probes a correct binary search visits for target t.
  task automatic build_plan(input int t, output int p[8], output int n);
    int lo, hi, mid;
    lo = 0; hi = MAXV; n = 0;
    for (int i = 0; i < 8; i++) p[i] = 0;
    while (lo <= hi && n < 8) begin
      mid = (lo + hi) / 2;
      p[n] = mid;
      n++;
      if (mid == t) break;
      if (mid < t) lo = mid + 1;
      else         hi = mid - 1;
    end
  endtask

  // Reference model
  int m_plan[8];
  int m_n, m_idx, m_inj;
  int m_probe, m_busy, m_done, m_found, m_fv, m_err, m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_probe = 0; m_busy = 0; m_done = 0; m_found = 0; m_fv = 0; m_err = 0;
      m_cnt = 0; m_idx = 0; m_n = 0;
    end else begin
      m_done = 0;
      if (m_busy != 0) begin
        m_cnt++;
        if (m_idx == m_n - 1) begin
          m_busy = 0;
          m_done = 1;
          if (m_inj != 0) begin
            m_err = 1; m_found = 0;
          end else begin
            m_found = 1; m_fv = m_plan[m_idx];
          end
        end else begin
          m_idx++;
          m_probe = m_plan[m_idx];
        end
      end else if (start) begin
        m_inj = inj;
        if (inj != 0) begin
          m_plan[0] = MAXV / 2;
          m_n = 1;
        end else begin
          build_plan(target, m_plan, m_n);
        end
        m_idx = 0; m_probe = m_plan[0]; m_busy = 1;
        m_found = 0; m_err = 0; m_fv = 0; m_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("probe", int'(probe), m_probe);
      chk("busy", int'(busy), m_busy);
      chk("done", int'(done), m_done);
      chk("found", int'(found), m_found);
      chk("found_value", int'(found_value), m_fv);
      chk("err", int'(err), m_err);
`ifdef CMP_SEARCH_PROBE_CNT_EN
      chk("probe_cnt", int'(probe_cnt), m_cnt);
`else
      chk("model_cnt_bound", int'(m_cnt <= W + 1), 1);
`endif
    end
  end

  task automatic run_search(input int t, input int mode, output int cyc);
    target = t; inj = mode; start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end while (!done && cyc < 20);
    chk("done_seen", int'(done), 1);
    inj = 0;
  endtask

  initial begin
    int cyc, pl[8], pn, n;
    rst = 1'b1; start = 1'b0; target = 0; inj = 0;

    build_plan(7, pl, pn);
    chk("plan7_len", pn, 4);
    chk("plan7_p1", pl[1], 5);
    chk("plan7_p3", pl[3], 7);
    build_plan(0, pl, pn);
    chk("plan0_len", pn, 3);
    chk("plan0_p2", pl[2], 0);

    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_probe", int'(probe), 0);
    chk("reset_done", int'(done), 0);

    run_search(3, 0, cyc);
    chk("t3_latency", cyc, 2);
    chk("t3_fv", int'(found_value), 3);
    chk("t3_found", int'(found), 1);
`ifdef CMP_SEARCH_PROBE_CNT_EN
    chk("t3_cnt", int'(probe_cnt), 1);
`endif
    repeat (2) @(negedge clk);
    chk("t3_hold_fv", int'(found_value), 3);

    run_search(7, 0, cyc);
    chk("t7_latency", cyc, 5);
    chk("t7_fv", int'(found_value), 7);
`ifdef CMP_SEARCH_PROBE_CNT_EN
    chk("t7_cnt", int'(probe_cnt), 4);
`endif
    @(negedge clk);

    run_search(0, 0, cyc);
    chk("t0_latency", cyc, 4);
    chk("t0_fv", int'(found_value), 0);
    chk("t0_probe", int'(probe), 0);
    @(negedge clk);

    // Back-to-back sweep: start stays high, next target loaded in each done cycle.
    target = 0; start = 1'b1;
    for (int t = 0; t <= MAXV; t++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 20);
      chk("sweep_done", int'(done), 1);
      chk("sweep_found", int'(found), 1);
      chk("sweep_fv", int'(found_value), t);
      if (t < MAXV) target = t + 1;
      else          start = 1'b0;
    end
    @(negedge clk);

    run_search(5, 1, cyc);
    chk("inj_gl_latency", cyc, 2);
    chk("inj_gl_err", int'(err), 1);
    chk("inj_gl_found", int'(found), 0);
    chk("inj_gl_fv", int'(found_value), 0);
    @(negedge clk);

    run_search(5, 2, cyc);
    chk("inj_zero_latency", cyc, 2);
    chk("inj_zero_err", int'(err), 1);
    chk("inj_zero_fv", int'(found_value), 0);
    @(negedge clk);

    // Reset two probes into a search, with start held high while busy.
    target = 7; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_probe", int'(probe), 5);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_probe", int'(probe), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_done", int'(done), 0);
    end

    // start held through the search must not disturb the probe sequence.
    target = 6; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 3) start = 1'b0;
    end while (!done && n < 20);
    chk("busy_start_latency", n, 4);
    chk("busy_start_fv", int'(found_value), 6);
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      int md;
      md = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_search(int'($urandom_range(0, MAXV)), md, cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
